// File: rtl/bcd_adjust.sv
// Post-ALU decimal adjust stage: captures one ADC/SBC result with its flags and
// returns the 6502 decimal-corrected accumulator and carry with a valid pulse.
module bcd_adjust (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       dec,
  input  logic       sub,
  input  logic [7:0] alu_out,
  input  logic       alu_c,
  input  logic       alu_hc,
  input  logic       alu_dhc,
  input  logic       alu_dc,
  input  logic       alu_n,
  input  logic       alu_v,
  input  logic       alu_z,
  output logic [7:0] result,
  output logic       c_out,
  output logic       n_out,
  output logic       v_out,
  output logic       z_out,
  output logic       valid,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADJ  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t next_state;

  logic [7:0] cap_out;
  logic       cap_c;
  logic       cap_hc;
  logic       cap_dhc;
  logic       cap_dc;
  logic       cap_n;
  logic       cap_v;
  logic       cap_z;
  logic       cap_sub;

  logic       accept;
  logic       load_bin;
  logic       load_dec;
  logic       lo_fix;
  logic       hi_fix;
  logic [7:0] fix;
  logic [7:0] adj_result;
  logic       adj_carry;
  logic       valid_next;
  logic       busy_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = dec ? ADJ : DONE;
      ADJ:     next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Correction terms: ADC fixes up on (half-)carry or an over-9 digit,
  // SBC fixes up a digit only when it borrowed.
  always_comb begin
    accept     = (state == IDLE) && start;
    load_bin   = accept && !dec;
    load_dec   = (state == ADJ);
    lo_fix     = cap_sub ? ~cap_hc : (cap_hc | cap_dhc);
    hi_fix     = cap_sub ? ~cap_c  : (cap_c  | cap_dc);
    fix        = {(hi_fix ? 4'h6 : 4'h0), (lo_fix ? 4'h6 : 4'h0)};
    adj_result = cap_sub ? (cap_out - fix) : (cap_out + fix);
    adj_carry  = cap_sub ? cap_c : (cap_c | cap_dc);
    valid_next = (next_state == DONE);
    busy_next  = (next_state != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cap_out <= 8'h00;
      cap_c   <= 1'b0;
      cap_hc  <= 1'b0;
      cap_dhc <= 1'b0;
      cap_dc  <= 1'b0;
      cap_n   <= 1'b0;
      cap_v   <= 1'b0;
      cap_z   <= 1'b0;
      cap_sub <= 1'b0;
    end else if (accept) begin
      cap_out <= alu_out;
      cap_c   <= alu_c;
      cap_hc  <= alu_hc;
      cap_dhc <= alu_dhc;
      cap_dc  <= alu_dc;
      cap_n   <= alu_n;
      cap_v   <= alu_v;
      cap_z   <= alu_z;
      cap_sub <= sub;
    end
  end

  // Binary results go straight to the outputs at capture; N/V/Z always keep
  // the binary ALU flags, even after a decimal correction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result <= 8'h00;
      c_out  <= 1'b0;
      n_out  <= 1'b0;
      v_out  <= 1'b0;
      z_out  <= 1'b0;
      valid  <= 1'b0;
      busy   <= 1'b0;
    end else begin
      valid <= valid_next;
      busy  <= busy_next;
      if (load_bin) begin
        result <= alu_out;
        c_out  <= alu_c;
        n_out  <= alu_n;
        v_out  <= alu_v;
        z_out  <= alu_z;
      end else if (load_dec) begin
        result <= adj_result;
        c_out  <= adj_carry;
        n_out  <= cap_n;
        v_out  <= cap_v;
        z_out  <= cap_z;
      end
    end
  end

endmodule

// File: tb/tb_bcd_adjust.sv
// Bench for bcd_adjust: directed plan cases plus random BCD/binary ADC/SBC ops
// checked against decimal arithmetic on the original operands.
module tb_bcd_adjust;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       dec;
  logic       sub;
  logic [7:0] alu_out;
  logic       alu_c;
  logic       alu_hc;
  logic       alu_dhc;
  logic       alu_dc;
  logic       alu_n;
  logic       alu_v;
  logic       alu_z;
  logic [7:0] result;
  logic       c_out;
  logic       n_out;
  logic       v_out;
  logic       z_out;
  logic       valid;
  logic       busy;

  int tests_run = 0;
  int tests_failed = 0;

  bcd_adjust dut (
    .clk(clk), .reset(reset), .start(start), .dec(dec), .sub(sub),
    .alu_out(alu_out), .alu_c(alu_c), .alu_hc(alu_hc), .alu_dhc(alu_dhc),
    .alu_dc(alu_dc), .alu_n(alu_n), .alu_v(alu_v), .alu_z(alu_z),
    .result(result), .c_out(c_out), .n_out(n_out), .v_out(v_out),
    .z_out(z_out), .valid(valid), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic checkBit(input string tag, input logic obs, input logic exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %b, expected %b", tag, obs, exp);
    end
  endtask

  task automatic checkCount(input string tag, input int obs, input int exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input bit d, input bit s, input logic [7:0] o, input bit c,
                               input bit hc, input bit dhc, input bit dc,
                               input bit n, input bit v, input bit z);
    dec = d; sub = s; alu_out = o; alu_c = c; alu_hc = hc; alu_dhc = dhc;
    alu_dc = dc; alu_n = n; alu_v = v; alu_z = z; start = 1'b1;
  endtask

  // ALU view of a+b+ci or a-b-(1-ci), plus the result a 6502 programmer expects.
  task automatic modelOp(input bit d, input bit s, input logic [7:0] a, input logic [7:0] b,
                         input bit ci, output logic [7:0] o, output bit c, output bit hc,
                         output bit dhc, output bit dc, output bit n, output bit v,
                         output bit z, output logic [7:0] exp_res, output bit exp_c);
    int bsum, lo, hi, av, bv, dv, tens, ones;
    logic [7:0] bop;
    logic [31:0] bsum_bits;
    bop = s ? ~b : b;
    bsum = int'(a) + int'(bop) + int'(ci);
    bsum_bits = bsum;
    o = bsum_bits[7:0];
    c = (bsum > 255);
    n = o[7];
    z = (o == 8'h00);
    v = (a[7] == bop[7]) && (o[7] != a[7]);
    if (!s) begin
      lo = int'(a[3:0]) + int'(b[3:0]) + int'(ci);
      hc = (lo > 15);
      dhc = ((lo % 16) > 9);
      hi = int'(a[7:4]) + int'(b[7:4]) + ((lo > 9) ? 1 : 0);
      dc = (hi > 9);
    end else begin
      lo = int'(a[3:0]) - int'(b[3:0]) - (ci ? 0 : 1);
      hc = (lo >= 0);
      dhc = 1'b0;
      dc = 1'b0;
    end
    if (d) begin
      av = 10 * int'(a[7:4]) + int'(a[3:0]);
      bv = 10 * int'(b[7:4]) + int'(b[3:0]);
      if (!s) begin
        dv = av + bv + int'(ci);
        exp_c = (dv > 99);
        dv = dv % 100;
      end else begin
        dv = av - bv - (ci ? 0 : 1);
        exp_c = (dv >= 0);
        if (dv < 0) dv = dv + 100;
      end
      tens = dv / 10;
      ones = dv % 10;
      exp_res = {tens[3:0], ones[3:0]};
    end else begin
      exp_res = o;
      exp_c = c;
    end
  endtask

  task automatic runOp(input string tag, input bit d, input bit s, input logic [7:0] o,
                       input bit c, input bit hc, input bit dhc, input bit dc,
                       input bit n, input bit v, input bit z,
                       input logic [7:0] exp_res, input bit exp_c);
    int cycles;
    applyStimulus(d, s, o, c, hc, dhc, dc, n, v, z);
    @(posedge clk); #1;
    start = 1'b0;
    cycles = 1;
    while (valid !== 1'b1 && cycles < 8) begin
      @(posedge clk); #1;
      cycles++;
    end
    checkCount({tag, " latency"}, cycles, d ? 2 : 1);
    checkBit({tag, " valid"}, valid, 1'b1);
    checkOutput({tag, " result"}, result, exp_res);
    checkBit({tag, " c_out"}, c_out, exp_c);
    checkBit({tag, " n_out"}, n_out, n);
    checkBit({tag, " v_out"}, v_out, v);
    checkBit({tag, " z_out"}, z_out, z);
    @(posedge clk); #1;
    checkBit({tag, " valid drop"}, valid, 1'b0);
    checkBit({tag, " busy drop"}, busy, 1'b0);
    checkOutput({tag, " result hold"}, result, exp_res);
  endtask

  initial begin
    logic [7:0] a, b, o, er;
    bit ci, c, hc, dhc, dc, n, v, z, ec, d, s;

    reset = 1'b1; start = 1'b0; dec = 1'b0; sub = 1'b0; alu_out = 8'h00;
    alu_c = 1'b0; alu_hc = 1'b0; alu_dhc = 1'b0; alu_dc = 1'b0;
    alu_n = 1'b0; alu_v = 1'b0; alu_z = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset result", result, 8'h00);
    checkBit("reset c_out", c_out, 1'b0);
    checkBit("reset valid", valid, 1'b0);
    checkBit("reset busy", busy, 1'b0);
    reset = 1'b0;
    @(posedge clk); #1;

    runOp("dec add 09+01", 1, 0, 8'h0A, 0, 0, 1, 0, 0, 0, 0, 8'h10, 1'b0);
    runOp("dec add 99+01", 1, 0, 8'h9A, 0, 0, 1, 1, 1, 0, 0, 8'h00, 1'b1);
    runOp("dec sub 10-01", 1, 1, 8'h0F, 1, 0, 0, 0, 0, 0, 0, 8'h09, 1'b1);
    runOp("dec sub 00-01", 1, 1, 8'hFF, 0, 0, 0, 0, 1, 0, 0, 8'h99, 1'b0);

    // start held for three cycles: accepted, ignored in DONE, accepted again
    applyStimulus(0, 0, 8'h9A, 1, 0, 0, 0, 1, 0, 0);
    @(posedge clk); #1;
    checkBit("hs first valid", valid, 1'b1);
    checkOutput("hs first result", result, 8'h9A);
    checkBit("hs first c_out", c_out, 1'b1);
    checkBit("hs first busy", busy, 1'b1);
    alu_out = 8'h33; alu_c = 1'b0;
    @(posedge clk); #1;
    checkBit("hs second valid", valid, 1'b0);
    checkBit("hs second busy", busy, 1'b0);
    checkOutput("hs second result", result, 8'h9A);
    alu_out = 8'h44; alu_c = 1'b1; alu_n = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    checkBit("hs third valid", valid, 1'b1);
    checkOutput("hs third result", result, 8'h44);
    checkBit("hs third n_out", n_out, 1'b0);
    @(posedge clk); #1;
    checkBit("hs third valid drop", valid, 1'b0);

    // abort a decimal op while it sits in ADJ
    applyStimulus(1, 0, 8'h0A, 0, 0, 1, 0, 0, 0, 0);
    @(posedge clk); #1;
    start = 1'b0;
    checkBit("abort busy in adj", busy, 1'b1);
    #2 reset = 1'b1;
    #1;
    checkOutput("abort result", result, 8'h00);
    checkBit("abort c_out", c_out, 1'b0);
    checkBit("abort busy", busy, 1'b0);
    checkBit("abort valid", valid, 1'b0);
    @(posedge clk); #1;
    checkBit("abort valid held", valid, 1'b0);
    reset = 1'b0;
    @(posedge clk); #1;
    checkBit("abort no late valid", valid, 1'b0);
    runOp("after abort", 1, 0, 8'h0A, 0, 0, 1, 0, 0, 0, 0, 8'h10, 1'b0);

    for (int i = 0; i < 40; i++) begin
      d = $urandom_range(0, 1);
      s = $urandom_range(0, 1);
      ci = $urandom_range(0, 1);
      if (d) begin
        a = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
        b = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      end else begin
        a = 8'($urandom);
        b = 8'($urandom);
      end
      modelOp(d, s, a, b, ci, o, c, hc, dhc, dc, n, v, z, er, ec);
      runOp($sformatf("rand %0d %s %s %h %h ci%0d", i, d ? "dec" : "bin",
                      s ? "sbc" : "adc", a, b, ci),
            d, s, o, c, hc, dhc, dc, n, v, z, er, ec);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
